// File: rtl/synth_audio_pkg.sv
// Shared types and frame geometry for the tone output stage.
package synth_audio_pkg;

    typedef logic signed [15:0] sample_t;

    localparam int SLOT_BITS  = 32;
    localparam int FRAME_BITS = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } i2s_state_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S bit/word clock generator: BCLK divider, frame bit counter and edge strobes.
module i2s_clk_gen
    import synth_audio_pkg::*;
#(
    parameter int BCLK_HALF = 12
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       run,
    output logic       bclk,
    output logic       lrclk,
    output logic [4:0] slot_pos,
    output logic       fall,
    output logic       wrap
);

    localparam int DW = $clog2(BCLK_HALF + 1);

    logic [DW-1:0] div_cnt;
    logic [5:0]    bit_cnt;
    logic          div_wrap;

    assign div_wrap = run && (div_cnt == DW'(BCLK_HALF - 1));
    assign fall     = div_wrap && bclk;
    assign wrap     = fall && (bit_cnt == 6'(FRAME_BITS - 1));
    assign lrclk    = bit_cnt[5];
    assign slot_pos = bit_cnt[4:0];

    // Everything parks at zero whenever the serializer is not running.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            bclk    <= 1'b0;
        end else if (!run) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            bclk    <= 1'b0;
        end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
            if (div_wrap)
                bclk <= ~bclk;
            if (fall)
                bit_cnt <= bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tone_i2s_tx.sv
// Tone capture/saturation, double buffer and mono I2S master serializer.
//  state | meaning
//  IDLE  | lines and counters held 0, waiting for ENABLE
//  RUN   | streaming frames, SAMPLE_REQ at each frame start
//  DRAIN | finishing the current frame after ENABLE dropped
module tone_i2s_tx
    import synth_audio_pkg::*;
#(
    parameter int BCLK_HALF  = 12,
    parameter int GAIN_SHIFT = 12
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        ENABLE,
    input  logic [31:0] TONE,
    input  logic        TONE_VALID,
    input  logic        CLR_FLAGS,
    output logic        SAMPLE_REQ,
    output logic        AUD_BCLK,
    output logic        AUD_DACLRCK,
    output logic        AUD_DACDAT,
    output logic        UNDERRUN,
    output logic        OVERRUN,
    output logic        CLIP
);

    i2s_state_t state, state_nxt;
    logic       frame_start;

    logic       fall, wrap;
    logic [4:0] slot_pos;

    logic signed [31:0]   shifted;
    logic                 clip_now;
    sample_t              sat_val;
    sample_t              hold, frame_sample;
    logic                 hold_full;
    logic [SLOT_BITS-1:0] sreg;

    i2s_clk_gen #(.BCLK_HALF(BCLK_HALF)) u_clk_gen (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .run      (state != IDLE),
        .bclk     (AUD_BCLK),
        .lrclk    (AUD_DACLRCK),
        .slot_pos (slot_pos),
        .fall     (fall),
        .wrap     (wrap)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        case (state)
            IDLE: begin
                if (ENABLE) begin
                    state_nxt   = RUN;
                    frame_start = 1'b1;
                end
            end
            RUN: begin
                frame_start = wrap;
                if (!ENABLE)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (ENABLE) begin
                    state_nxt   = RUN;
                    frame_start = wrap;
                end else if (wrap) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign shifted  = $signed(TONE) >>> GAIN_SHIFT;
    assign clip_now = (shifted > 32'sd32767) || (shifted < -32'sd32768);
    assign sat_val  = !clip_now ? shifted[15:0] : (shifted[31] ? 16'h8000 : 16'h7FFF);

    // A strobe coinciding with frame start lands in hold for the next frame.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hold         <= '0;
            hold_full    <= 1'b0;
            frame_sample <= '0;
            SAMPLE_REQ   <= 1'b0;
        end else begin
            SAMPLE_REQ <= frame_start;
            if (TONE_VALID)
                hold <= sat_val;
            if (frame_start) begin
                if (hold_full)
                    frame_sample <= hold;
                hold_full <= TONE_VALID;
            end else if (TONE_VALID) begin
                hold_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            UNDERRUN <= 1'b0;
            OVERRUN  <= 1'b0;
            CLIP     <= 1'b0;
        end else begin
            UNDERRUN <= (frame_start && !hold_full) | (UNDERRUN & ~CLR_FLAGS);
            OVERRUN  <= (TONE_VALID && hold_full && !frame_start) | (OVERRUN & ~CLR_FLAGS);
            CLIP     <= (TONE_VALID && clip_now) | (CLIP & ~CLR_FLAGS);
        end
    end

    // Loading on the fall into slot position 1 gives the one-BCLK I2S delay.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            sreg <= '0;
        else if (state == IDLE)
            sreg <= '0;
        else if (fall)
            sreg <= (slot_pos == 5'd0) ? {frame_sample, 16'h0000} : {sreg[SLOT_BITS-2:0], 1'b0};
    end

    assign AUD_DACDAT = sreg[SLOT_BITS-1];

endmodule

// File: tb/tb_tone_i2s_tx.sv
// Self-checking bench for tone_i2s_tx: serial frames decoded and compared to a sample/flag model.
module tb_tone_i2s_tx;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        ENABLE = 1'b0;
    logic [31:0] TONE = '0;
    logic        TONE_VALID = 1'b0;
    logic        CLR_FLAGS = 1'b0;
    logic        SAMPLE_REQ, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, UNDERRUN, OVERRUN, CLIP;

    tone_i2s_tx dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .ENABLE      (ENABLE),
        .TONE        (TONE),
        .TONE_VALID  (TONE_VALID),
        .CLR_FLAGS   (CLR_FLAGS),
        .SAMPLE_REQ  (SAMPLE_REQ),
        .AUD_BCLK    (AUD_BCLK),
        .AUD_DACLRCK (AUD_DACLRCK),
        .AUD_DACDAT  (AUD_DACDAT),
        .UNDERRUN    (UNDERRUN),
        .OVERRUN     (OVERRUN),
        .CLIP        (CLIP)
    );

    initial forever #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_req = 0;

    logic [63:0] rx_dat_q[$];
    logic [63:0] rx_lr_q[$];
    logic [15:0] exp_q[$];

    logic [15:0] m_cur = '0;
    logic [15:0] m_pend = '0;
    bit          m_pend_v = 0;
    bit          m_under = 0, m_over = 0, m_clip = 0;

    initial forever begin
        @(negedge CLK);
        cyc++;
    end

    // Serial receiver: a frame is the 64 BCLK rising edges following a SAMPLE_REQ.
    initial begin : monitor
        logic [63:0] mon_dat;
        logic [63:0] mon_lr;
        int          mon_idx;
        bit          mon_act;
        logic        mon_prev;
        mon_dat = '0; mon_lr = '0; mon_idx = 0; mon_act = 0; mon_prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RESET_N) begin
                mon_act = 0;
                mon_idx = 0;
                mon_prev = 1'b0;
            end else begin
                if (SAMPLE_REQ) begin
                    mon_act = 1;
                    mon_idx = 0;
                end
                if (AUD_BCLK && !mon_prev && mon_act) begin
                    mon_dat = {mon_dat[62:0], AUD_DACDAT};
                    mon_lr  = {mon_lr[62:0], AUD_DACLRCK};
                    mon_idx++;
                    if (mon_idx == 64) begin
                        rx_dat_q.push_back(mon_dat);
                        rx_lr_q.push_back(mon_lr);
                        mon_act = 0;
                    end
                end
                mon_prev = AUD_BCLK;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {clip, sample}: floor(TONE / 4096) clamped to the signed 16-bit range.
    function automatic logic [16:0] model_sat(input logic [31:0] t);
        logic signed [31:0] ts;
        longint v, q;
        ts = t;
        v = ts;
        if (v >= 0) q = v / 4096;
        else        q = -((-v + 4095) / 4096);
        if (q > 32767)  return {1'b1, 16'h7FFF};
        if (q < -32768) return {1'b1, 16'h8000};
        return {1'b0, q[15:0]};
    endfunction

    function automatic logic [31:0] rand_tone();
        case ($urandom_range(0, 2))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 32'h07FF_FFFF));
            default: return 32'h0 - 32'($urandom_range(0, 32'h0800_0000));
        endcase
    endfunction

    task automatic strobe(input logic [31:0] t);
        logic [16:0] r;
        @(negedge CLK);
        TONE = t;
        TONE_VALID = 1'b1;
        @(negedge CLK);
        TONE_VALID = 1'b0;
        r = model_sat(t);
        if (m_pend_v) m_over = 1;
        if (r[16]) m_clip = 1;
        m_pend = r[15:0];
        m_pend_v = 1;
    endtask

    task automatic clr_flags();
        @(negedge CLK);
        CLR_FLAGS = 1'b1;
        @(negedge CLK);
        CLR_FLAGS = 1'b0;
        m_under = 0; m_over = 0; m_clip = 0;
    endtask

    task automatic on_frame_start();
        if (m_pend_v) m_cur = m_pend;
        else          m_under = 1;
        m_pend_v = 0;
        exp_q.push_back(m_cur);
    endtask

    task automatic wait_req(input int limit);
        bit seen;
        seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge CLK);
            seen = SAMPLE_REQ;
        end
        chk("req_seen", 64'(seen), 64'd1);
        last_req = cyc;
    endtask

    task automatic check_rx();
        logic [63:0] d, l;
        logic [15:0] s;
        bit avail;
        avail = (rx_dat_q.size() > 0) && (exp_q.size() > 0);
        chk("rx_frame_avail", 64'(avail), 64'd1);
        if (avail) begin
            d = rx_dat_q.pop_front();
            l = rx_lr_q.pop_front();
            s = exp_q.pop_front();
            chk("slot_data", d, {1'b0, s, 15'h0, 1'b0, s, 15'h0});
            chk("lrclk_bits", l, {32'h0, 32'hFFFF_FFFF});
        end
    endtask

    task automatic check_flags(input string tag);
        chk(tag, 64'({UNDERRUN, OVERRUN, CLIP}), 64'({m_under, m_over, m_clip}));
    endtask

    // Strobe n values into the running frame, then at the next frame start check the finished frame.
    task automatic run_frame(input int n, input logic [31:0] a, input logic [31:0] b);
        if (n > 0) begin
            repeat (40) @(negedge CLK);
            strobe(a);
        end
        if (n > 1) begin
            repeat (200) @(negedge CLK);
            strobe(b);
        end
        wait_req(2000);
        on_frame_start();
        check_rx();
        check_flags("flags");
    endtask

    initial begin : stim
        int   first_req;
        int   rises, t0;
        logic pb;
        bit   saw;

        repeat (5) @(negedge CLK);
        chk("reset_outputs", 64'({SAMPLE_REQ, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, UNDERRUN, OVERRUN, CLIP}), 64'd0);
        RESET_N = 1'b1;
        repeat (10) @(negedge CLK);
        chk("idle_outputs", 64'({SAMPLE_REQ, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT}), 64'd0);

        ENABLE = 1'b1;
        wait_req(5);
        on_frame_start();
        first_req = last_req;
        @(negedge CLK);
        chk("req_width", 64'(SAMPLE_REQ), 64'd0);

        rises = 0; t0 = 0; pb = AUD_BCLK;
        for (int i = 0; i < 100 && rises < 2; i++) begin
            @(negedge CLK);
            if (AUD_BCLK && !pb) begin
                rises++;
                if (rises == 1) t0 = cyc;
                else            chk("bclk_period", 64'(cyc - t0), 64'd24);
            end
            pb = AUD_BCLK;
        end
        chk("bclk_rises", 64'(rises), 64'd2);

        run_frame(1, 32'h0012_3000, 32'h0);
        chk("frame_period", 64'(last_req - first_req), 64'd1536);
        clr_flags();
        run_frame(1, 32'h7FFF_FFFF, 32'h0);
        run_frame(1, 32'h8000_0000, 32'h0);
        clr_flags();
        run_frame(1, 32'hFFFF_F000, 32'h0);
        run_frame(0, 32'h0, 32'h0);
        run_frame(2, 32'h0045_6000, 32'h0078_9000);
        run_frame(1, rand_tone(), 32'h0);
        clr_flags();
        check_flags("clr_flags");

        for (int k = 0; k < 10; k++)
            run_frame($urandom_range(0, 2), rand_tone(), rand_tone());

        repeat (250) @(negedge CLK);
        ENABLE = 1'b0;
        strobe(rand_tone());
        saw = 0;
        for (int i = 0; i < 1400; i++) begin
            @(negedge CLK);
            if (SAMPLE_REQ) saw = 1;
        end
        chk("drain_no_req", 64'(saw), 64'd0);
        chk("drain_idle_lines", 64'({AUD_BCLK, AUD_DACLRCK, AUD_DACDAT}), 64'd0);
        check_rx();
        check_flags("drain_flags");

        ENABLE = 1'b1;
        wait_req(3);
        on_frame_start();
        run_frame(1, rand_tone(), 32'h0);

        repeat (970) @(negedge CLK);
        chk("pre_reset_lrclk", 64'(AUD_DACLRCK), 64'd1);
        RESET_N = 1'b0;
        #1;
        chk("async_reset_outputs", 64'({SAMPLE_REQ, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, UNDERRUN, OVERRUN, CLIP}), 64'd0);
        rx_dat_q.delete();
        rx_lr_q.delete();
        exp_q.delete();
        m_cur = '0; m_pend_v = 0; m_under = 0; m_over = 0; m_clip = 0;
        repeat (4) @(negedge CLK);
        RESET_N = 1'b1;
        wait_req(5);
        on_frame_start();
        run_frame(1, 32'h0012_3000, 32'h0);
        run_frame(0, 32'h0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #(2_000_000ns);
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench time limit");
    end

endmodule
